// File: rtl/fir_mc_engine_if.sv
// Sample handshake, result strobe and coefficient register bus of fir_mc_engine.
// The engine connects through the slave modport; the driving side uses master.
interface fir_mc_engine_if #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int CHAN_W = 2
);
  logic                     In_valid;
  logic                     In_ready;
  logic [CHAN_W-1:0]        In_chan;
  logic signed [DATA_W-1:0] Din;
  logic                     Out_valid;
  logic [CHAN_W-1:0]        Out_chan;
  logic signed [DATA_W-1:0] Dout;
  logic                     Chan_err;
  logic                     load;
  logic [7:0]               write_address;
  logic [COEF_W-1:0]        write_value;
  logic [7:0]               read_address;
  logic [COEF_W-1:0]        read_value;

  modport slave (
    input  In_valid, In_chan, Din, load, write_address, write_value, read_address,
    output In_ready, Out_valid, Out_chan, Dout, Chan_err, read_value
  );

  modport master (
    output In_valid, In_chan, Din, load, write_address, write_value, read_address,
    input  In_ready, Out_valid, Out_chan, Dout, Chan_err, read_value
  );
endinterface

// File: rtl/fir_mc_engine.sv
// Time-multiplexed single-MAC multi-channel FIR with a shared, register-loaded coefficient bank.
// Build option COEF_SHADOW_EN: coefficient writes land in a shadow bank copied to the active bank in IDLE.
module fir_mc_engine #(
  parameter int DATA_W     = 12,
  parameter int COEF_W     = 12,
  parameter int TAPS       = 16,
  parameter int CHANNELS   = 2,
  parameter int FRAC_SHIFT = 10
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Hlt,
  fir_mc_engine_if.slave bus
);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CHAN_W = $clog2(CHANNELS) + 1;
  localparam int CIDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [7:0]               TAPS_A   = 8'(TAPS);
  localparam logic [CHAN_W-1:0]        CHAN_LIM = CHAN_W'(CHANNELS);
  localparam logic [K_W-1:0]           K_LAST   = K_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0]  RND      = ACC_W'(1 << (FRAC_SHIFT - 1));
  localparam logic signed [DATA_W-1:0] DOUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DOUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_mem [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] h_act [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [K_W-1:0]           k_q;
  logic [CHAN_W-1:0]        chan_q;
  logic signed [DATA_W-1:0] dout_q;
  logic                     out_valid_q;
  logic                     chan_err_q;

  logic                     accept_ok, accept_bad, mac_en, out_en, coef_we;
  logic [CIDX_W-1:0]        in_idx, cur_idx;
  logic [K_W-1:0]           waddr, raddr;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rnd_sum, shifted;
  logic signed [DATA_W-1:0] sat_val;

  assign in_idx  = bus.In_chan[CIDX_W-1:0];
  assign cur_idx = chan_q[CIDX_W-1:0];
  assign waddr   = bus.write_address[K_W-1:0];
  assign raddr   = bus.read_address[K_W-1:0];
  assign coef_we = bus.load && (bus.write_address < TAPS_A);

  assign bus.In_ready   = (state_q == IDLE) && !Hlt;
  assign bus.Out_valid  = out_valid_q;
  assign bus.Out_chan   = chan_q;
  assign bus.Dout       = dout_q;
  assign bus.Chan_err   = chan_err_q;
  assign bus.read_value = (bus.read_address < TAPS_A) ? h_act[raddr] : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    mac_en     = 1'b0;
    out_en     = 1'b0;
    case (state_q)
      IDLE: if (bus.In_valid && !Hlt) begin
        if (bus.In_chan < CHAN_LIM) begin
          accept_ok = 1'b1;
          state_d   = MAC;
        end else begin
          accept_bad = 1'b1;
        end
      end
      MAC: if (!Hlt) begin
        mac_en = 1'b1;
        if (k_q == K_LAST) state_d = OUT;
      end
      OUT: if (!Hlt) begin
        out_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prod = PROD_W'(x_mem[cur_idx][k_q]) * PROD_W'(h_act[k_q]);

  // Round half up by biasing before the arithmetic shift, then clamp to the output range.
  always_comb begin
    rnd_sum = acc_q + RND;
    shifted = rnd_sum >>> FRAC_SHIFT;
    if (shifted > ACC_W'(DOUT_MAX))      sat_val = DOUT_MAX;
    else if (shifted < ACC_W'(DOUT_MIN)) sat_val = DOUT_MIN;
    else                                 sat_val = shifted[DATA_W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q       <= '0;
      k_q         <= '0;
      chan_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      chan_err_q  <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned t = 0; t < TAPS; t++)
          x_mem[CIDX_W'(c)][K_W'(t)] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      chan_err_q  <= accept_bad;
      if (accept_ok) begin
        for (int unsigned t = 1; t < TAPS; t++)
          x_mem[in_idx][K_W'(t)] <= x_mem[in_idx][K_W'(t - 1)];
        x_mem[in_idx][K_W'(0)] <= bus.Din;
        acc_q  <= '0;
        k_q    <= '0;
        chan_q <= bus.In_chan;
      end
      if (mac_en) begin
        acc_q <= acc_q + ACC_W'(prod);
        k_q   <= k_q + K_W'(1);
      end
      if (out_en) begin
        dout_q      <= sat_val;
        out_valid_q <= 1'b1;
      end
    end
  end

`ifdef COEF_SHADOW_EN
  logic signed [COEF_W-1:0] h_sh [TAPS];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned t = 0; t < TAPS; t++) h_sh[K_W'(t)] <= '0;
    end else if (coef_we) begin
      h_sh[waddr] <= bus.write_value;
    end
  end

  // Whole-bank copy only while idle keeps every computation on one coefficient set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned t = 0; t < TAPS; t++) h_act[K_W'(t)] <= '0;
    end else if (state_q == IDLE) begin
      for (int unsigned t = 0; t < TAPS; t++) h_act[K_W'(t)] <= h_sh[K_W'(t)];
    end
  end
`else
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned t = 0; t < TAPS; t++) h_act[K_W'(t)] <= '0;
    end else if (coef_we) begin
      h_act[waddr] <= bus.write_value;
    end
  end
`endif
endmodule
